mips_bus_master: RTL and testbench
==================================

MIPS_BUS_MASTER -- requirements
Module: mips_bus_master

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset.
REQ-002 Parameter WAIT_LIMIT, default 0: maximum cycles waitrequest may stall one transfer; 0 = unlimited.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-high reset.
REQ-005 req_valid  input  1  core request present.
REQ-006 req_ready  output  1  block can accept a request.
REQ-007 req_write  input  1  1 = store, 0 = load.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_size  input  2  00 = byte, 01 = half, 10 = word; 11 = illegal.
REQ-010 req_signed  input  1  sign-extend load result (byte/half only).
REQ-011 req_wdata  input  32  store data, right-justified.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-014 resp_err  output  1  misaligned, illegal size or timeout; valid with resp_valid.
REQ-015 address  output  32  bus word address, bits [1:0] always 00.
REQ-016 write  output  1  bus write strobe.
REQ-017 read  output  1  bus read strobe.
REQ-018 waitrequest  input  1  responder stall.
REQ-019 writedata  output  32  bus write data.
REQ-020 byteenable  output  4  lane enables; bit n = writedata/readdata bits [8n+7:8n].
REQ-021 readdata  input  32  responder data, valid the cycle after an accepted read.

Function
REQ-022 The FSM SHALL have states IDLE, BUS, RDATA and RESP; req_ready = 1 only in IDLE.
REQ-023 A request SHALL be accepted on an edge with req_valid && req_ready; addr, size, signed, write and wdata SHALL be latched.
REQ-024 Misalignment (half with addr[0] = 1, word with addr[1:0] != 00) or size 11 SHALL go IDLE->RESP with no bus strobe; RESP SHALL give resp_err = 1 and resp_rdata = 0.
REQ-025 In BUS, read or write SHALL be 1 (never both), with address = {addr[31:2],2'b00}; address, byteenable and writedata SHALL stay constant while waitrequest = 1.
REQ-026 byteenable: byte = 1 << addr[1:0]; half = 0011 if addr[1] = 0, else 1100; word = 1111; reads use the same enables.
REQ-027 writedata SHALL replicate the byte or half into every lane, so the enabled lane carries wdata[7:0] or wdata[15:0].
REQ-028 On a BUS cycle with waitrequest = 0, the FSM SHALL go to RESP for writes and to RDATA for reads; strobes drop the next cycle.
REQ-029 In RDATA, readdata SHALL be sampled at the edge; the selected lane(s) SHALL be zero-extended, or sign-extended if req_signed; words SHALL pass unchanged.
REQ-030 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE.
REQ-031 Latency with zero wait states, from the accept edge: write resp_valid 2 cycles later, read 3, error 1; each waitrequest cycle adds 1.
REQ-032 If WAIT_LIMIT != 0 and waitrequest stays 1 for WAIT_LIMIT consecutive BUS cycles, the FSM SHALL drop the strobes and go to RESP with resp_err = 1.
REQ-033 Requests presented while req_ready = 0 SHALL be ignored and SHALL NOT be queued.

Reset
REQ-034 Reset SHALL force state IDLE and outputs read = write = resp_valid = resp_err = 0, with address, writedata, byteenable and resp_rdata = 0.
REQ-035 Reset mid-transaction SHALL abandon it: strobes deassert from the next cycle and no resp_valid is produced for the abandoned request.
REQ-036 req_ready SHALL be 1 in the first cycle after reset is released.

Verification
REQ-037 lw at BFC00018, waitrequest = 0, readdata = FFFFFFFF -> read = 1 and address = BFC00018 one cycle after the accept edge; resp_valid with resp_rdata = FFFFFFFF 3 cycles after acceptance.
REQ-038 lb signed at BFC00002, readdata = 12805634 -> byteenable = 0100, resp_rdata = FFFFFF80; the same access as lbu -> resp_rdata = 00000080.
REQ-039 sh at BFC00006, wdata = 0000ABCD, waitrequest high for 3 cycles -> write held 4 cycles, byteenable = 1100, writedata = ABCDABCD; resp_valid 5 cycles after acceptance, resp_err = 0.
REQ-040 lw at BFC00002 -> no read or write strobe; resp_valid with resp_err = 1 one cycle after acceptance.
REQ-041 WAIT_LIMIT = 4, waitrequest stuck at 1 -> strobe drops after 4 BUS cycles; resp_err = 1.
REQ-042 Reset asserted during a stalled read -> read = 0 the next cycle, no resp_valid, req_ready = 1 after release.

Source files
------------

// File: rtl/mips_bus_master.sv
// Bridges a MIPS core load/store request onto a word-addressed bus with byte enables,
// waitrequest stalls, one-cycle-late read data, lane extraction and sign/zero extension.
module mips_bus_master #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  // Core side. Handshake: a request transfers on a rising edge where req_valid && req_ready;
  // resp_valid is a single-cycle pulse with resp_rdata/resp_err valid alongside it.
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  // Bus side
  output logic [31:0] address,
  output logic        write,
  output logic        read,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata,
  // Debug: current FSM state (0 IDLE, 1 BUS, 2 RDATA, 3 RESP)
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    RDATA = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned CNT_W = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

  state_e            state_q, state_d;
  logic [31:0]       addr_q, addr_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic              wr_q, wr_d;
  logic [3:0]        be_q, be_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;

  logic              req_bad;
  logic [3:0]        req_be;
  logic [31:0]       req_wdata_rep;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_ext;

  // Request decode: alignment check, lane enables and lane-replicated store data.
  always_comb begin
    req_bad       = 1'b0;
    req_be        = 4'b0000;
    req_wdata_rep = req_wdata;
    case (req_size)
      2'b00: begin
        req_be        = 4'b0001 << req_addr[1:0];
        req_wdata_rep = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        req_bad       = req_addr[0];
        req_be        = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wdata_rep = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        req_bad = (req_addr[1:0] != 2'b00);
        req_be  = 4'b1111;
      end
      default: req_bad = 1'b1;
    endcase
  end

  // Load path: pick the addressed lane(s) out of readdata and extend.
  always_comb begin
    rd_byte  = 8'h00;
    rd_half  = addr_q[1] ? readdata[31:16] : readdata[15:0];
    load_ext = readdata;
    case (addr_q[1:0])
      2'b00:   rd_byte = readdata[7:0];
      2'b01:   rd_byte = readdata[15:8];
      2'b10:   rd_byte = readdata[23:16];
      default: rd_byte = readdata[31:24];
    endcase
    case (size_q)
      2'b00:   load_ext = {{24{signed_q & rd_byte[7]}}, rd_byte};
      2'b01:   load_ext = {{16{signed_q & rd_half[15]}}, rd_half};
      default: load_ext = readdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    size_d     = size_q;
    signed_d   = signed_q;
    wr_d       = wr_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d     = req_addr;
          size_d     = req_size;
          signed_d   = req_signed;
          wr_d       = req_write;
          be_d       = req_be;
          wdata_d    = req_wdata_rep;
          rdata_d    = 32'h0;
          err_d      = req_bad;
          wait_cnt_d = '0;
          state_d    = req_bad ? RESP : BUS;
        end
      end
      BUS: begin
        if (!waitrequest) begin
          state_d = wr_q ? RESP : RDATA;
        end else if ((WAIT_LIMIT != 0) && (wait_cnt_q == LIMIT_M1)) begin
          // Responder stalled too long: give up on this transfer.
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      RDATA: begin
        rdata_d = load_ext;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= 32'h0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      wr_q       <= 1'b0;
      be_q       <= 4'b0000;
      wdata_q    <= 32'h0;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      size_q     <= size_d;
      signed_q   <= signed_d;
      wr_q       <= wr_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign read       = (state_q == BUS) && !wr_q;
  assign write      = (state_q == BUS) && wr_q;
  assign address    = {addr_q[31:2], 2'b00};
  assign writedata  = wdata_q;
  assign byteenable = be_q;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = resp_valid ? rdata_q : 32'h0;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mips_bus_master.sv
// Bench for mips_bus_master: vector table of loads/stores/errors with a responder driver,
// response scoreboard, plus hand-written reset sequences.
module tb_mips_bus_master;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] address, writedata, readdata;
  logic        write, read, waitrequest;
  logic [3:0]  byteenable;
  logic [1:0]  dbg_state;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [32:0] exp_q[$];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          nwait;
    logic        bad;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[15];

  mips_bus_master #(.WAIT_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .address(address), .write(write), .read(read),
    .waitrequest(waitrequest), .writedata(writedata), .byteenable(byteenable),
    .readdata(readdata), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard: every resp_valid must match the oldest expected response
  always @(negedge clk) begin
    logic [32:0] e;
    if (resp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 expected no response at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("resp_rdata", resp_rdata, e[31:0]);
        check("resp_err", {31'b0, resp_err}, {31'b0, e[32]});
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int  nbus, lat;
    bit  seen;
    nbus = v.bad ? 0 : ((v.nwait >= LIM) ? LIM : v.nwait + 1);
    lat  = v.bad ? 1 : ((v.nwait >= LIM) ? LIM + 1 : (v.wr ? 2 + v.nwait : 3 + v.nwait));
    check("req_ready_before", {31'b0, req_ready}, 32'd1);
    req_valid   = 1'b1;
    req_write   = v.wr;
    req_addr    = v.addr;
    req_size    = v.size;
    req_signed  = v.sgn;
    req_wdata   = v.wdata;
    waitrequest = 1'b0;
    readdata    = $urandom();
    @(posedge clk);
    #1;
    exp_q.push_back({v.exp_err, v.exp_rdata});
    // a different request held while busy must be ignored
    req_write = ~v.wr;
    req_addr  = 32'h0000_1000;
    req_size  = 2'b10;
    req_wdata = 32'h5555_AAAA;
    seen = 1'b0;
    for (int c = 1; c <= 20 && !seen; c++) begin
      @(negedge clk);
      if (c <= nbus) begin
        check("read_strobe", {31'b0, read}, {31'b0, ~v.wr});
        check("write_strobe", {31'b0, write}, {31'b0, v.wr});
        check("address", address, {v.addr[31:2], 2'b00});
        check("byteenable", {28'b0, byteenable}, {28'b0, v.exp_be});
        if (v.wr) check("writedata", writedata, v.exp_wdata);
        check("req_ready_busy", {31'b0, req_ready}, 32'd0);
        waitrequest = (c <= v.nwait);
      end else if (c == nbus + 1) begin
        check("strobes_dropped", {30'b0, read, write}, 32'd0);
        if (!v.wr && !v.bad && v.nwait < LIM) readdata = v.rdata;
        else readdata = $urandom();
      end else begin
        readdata = $urandom();
      end
      if (resp_valid === 1'b1) begin
        seen = 1'b1;
        check("latency", 32'(c), 32'(lat));
        req_valid   = 1'b0;
        waitrequest = 1'b0;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_fail++;
      $display("FAIL resp_timeout: got no resp_valid expected one after %0d cycles", lat);
      req_valid = 1'b0;
      waitrequest = 1'b0;
      exp_q.delete();
    end
    @(negedge clk);
    check("req_ready_after", {31'b0, req_ready}, 32'd1);
    check("resp_valid_after", {31'b0, resp_valid}, 32'd0);
  endtask

  initial begin
    vec_t v;
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t v;
    //          wr    addr          sz     sgn   wdata         rdata         nw bad   be      exp_wdata     exp_rdata     err
    vecs[0]  = '{1'b0, 32'hBFC00018, 2'b10, 1'b0, 32'h0,        32'hFFFFFFFF, 0, 1'b0, 4'b1111, 32'h0,        32'hFFFFFFFF, 1'b0};
    vecs[1]  = '{1'b0, 32'hBFC00002, 2'b00, 1'b1, 32'h0,        32'h12805634, 0, 1'b0, 4'b0100, 32'h0,        32'hFFFFFF80, 1'b0};
    vecs[2]  = '{1'b0, 32'hBFC00002, 2'b00, 1'b0, 32'h0,        32'h12805634, 0, 1'b0, 4'b0100, 32'h0,        32'h00000080, 1'b0};
    vecs[3]  = '{1'b1, 32'hBFC00006, 2'b01, 1'b0, 32'h0000ABCD, 32'h0,        3, 1'b0, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
    vecs[4]  = '{1'b0, 32'hBFC00002, 2'b10, 1'b0, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[5]  = '{1'b0, 32'hBFC00000, 2'b10, 1'b0, 32'h0,        32'h13572468, 4, 1'b0, 4'b1111, 32'h0,        32'h0,        1'b1};
    vecs[6]  = '{1'b0, 32'hBFC00002, 2'b01, 1'b1, 32'h0,        32'h80011234, 0, 1'b0, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
    vecs[7]  = '{1'b0, 32'hBFC00000, 2'b01, 1'b0, 32'h0,        32'h1234F00D, 1, 1'b0, 4'b0011, 32'h0,        32'h0000F00D, 1'b0};
    vecs[8]  = '{1'b1, 32'hBFC00001, 2'b00, 1'b0, 32'h123456A5, 32'h0,        0, 1'b0, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0};
    vecs[9]  = '{1'b1, 32'hBFC00010, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1, 1'b0, 4'b1111, 32'hDEADBEEF, 32'h0,        1'b0};
    vecs[10] = '{1'b0, 32'hBFC00000, 2'b11, 1'b0, 32'h0,        32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[11] = '{1'b1, 32'hBFC00001, 2'b01, 1'b0, 32'h00001234, 32'h0,        0, 1'b1, 4'b0000, 32'h0,        32'h0,        1'b1};
    vecs[12] = '{1'b0, 32'hBFC00003, 2'b00, 1'b1, 32'h0,        32'h7F000000, 0, 1'b0, 4'b1000, 32'h0,        32'h0000007F, 1'b0};
    vecs[13] = '{1'b0, 32'hBFC00004, 2'b10, 1'b1, 32'h0,        32'h80000000, 2, 1'b0, 4'b1111, 32'h0,        32'h80000000, 1'b0};
    vecs[14] = '{1'b0, 32'h00000000, 2'b00, 1'b0, 32'h0,        32'hFFFFFFC3, 2, 1'b0, 4'b0001, 32'h0,        32'h000000C3, 1'b0};

    // reset block
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'h0; req_size = 2'b00;
    req_signed = 1'b0; req_wdata = 32'h0; waitrequest = 1'b0; readdata = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_strobes", {30'b0, read, write}, 32'd0);
    check("rst_resp", {30'b0, resp_valid, resp_err}, 32'd0);
    check("rst_address", address, 32'h0);
    check("rst_writedata", writedata, 32'h0);
    check("rst_byteenable", {28'b0, byteenable}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_state", {30'b0, dbg_state}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_release", {31'b0, req_ready}, 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // second pass with random stall lengths on the good transfers
    foreach (vecs[i]) begin
      if (!vecs[i].bad && vecs[i].nwait < LIM) begin
        v = vecs[i];
        v.nwait = $urandom_range(0, 3);
        run_vec(v);
      end
    end

    // reset during a stalled read abandons it
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'hBFC00020; req_size = 2'b10;
    req_signed = 1'b0; waitrequest = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("stall_read_1", {31'b0, read}, 32'd1);
    @(negedge clk);
    check("stall_read_2", {31'b0, read}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_read", {31'b0, read}, 32'd0);
    check("mid_rst_resp", {31'b0, resp_valid}, 32'd0);
    check("mid_rst_address", address, 32'h0);
    reset = 1'b0; waitrequest = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", {31'b0, req_ready}, 32'd1);
    check("mid_rst_no_resp", {31'b0, resp_valid}, 32'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_idle", {30'b0, dbg_state}, 32'd0);

    // normal operation resumes after the abandoned transfer
    run_vec(vecs[0]);
    run_vec(vecs[3]);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
